// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_e;

    // System clocks per oversampling tick, truncated; 0 means the clock is too slow.
    function automatic int calc_clks_per_tick(input int clk_rate, input int baud_rate,
                                              input int oversample);
        longint denom;
        denom = longint'(baud_rate) * longint'(oversample);
        return int'(longint'(clk_rate) / denom);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divides the system clock down to the oversampling tick rate.
// The synchronous clear restarts the count so the tick phase can be aligned to
// an external event such as a start-bit edge.
module uart_baud_tick #(
    parameter int CLKS_PER_TICK = 1
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] count;

    // Wrap at the terminal count, or restart on clear.
    always_ff @(posedge clock) begin
        if (rst || clear || count == TERMINAL) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == TERMINAL);

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with valid/ready output.
// Optional macro UART_RX_MAJORITY_EN: each bit is a 2-of-3 vote over the ticks
// around mid-bit, decided one tick later than the single-sample build.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_RATE    = 100000000,
    parameter int BAUD_RATE   = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CLKS_PER_TICK = calc_clks_per_tick(CLK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam int TW            = $clog2(OVERSAMPLE);
    localparam int BW            = $clog2(DATA_BITS + 1);
    localparam int MID           = OVERSAMPLE / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int DECIDE        = MID + 1;
`else
    localparam int DECIDE        = MID;
`endif

    localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] DECIDE_IDX = TW'(DECIDE);
    localparam logic [BW-1:0] LAST_DATA  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP  = 1'(STOP_BITS - 1);
    localparam parity_mode_e  PAR        = parity_mode_e'(PARITY_MODE[1:0]);

    generate
        if (CLKS_PER_TICK < 1) begin : g_bad_rate
            $error("uart_rx_core: CLK_RATE below BAUD_RATE*OVERSAMPLE");
        end
        if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
            $error("uart_rx_core: OVERSAMPLE must be even and at least 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_rx_core: DATA_BITS must be 5..9");
        end
        if (PARITY_MODE < 0 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_frame
            $error("uart_rx_core: PARITY_MODE must be 0..2 and STOP_BITS 1..2");
        end
    endgenerate

    rx_state_e              state;
    logic                   rx_meta;
    logic                   rx_sync;
    logic                   tick;
    logic                   tick_clear;
    logic [TW-1:0]          tick_idx;
    logic [BW-1:0]          bit_cnt;
    logic                   stop_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   parity_bad;
    logic                   frame_bad;
    logic                   bit_val;
    logic                   decide;
    logic                   par_expect;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clock) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
        end
    end

    // Restart the tick phase on the falling edge that opens a frame.
    assign tick_clear = (state == IDLE) && !rx_sync;

    uart_baud_tick #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_baud_tick (
        .clock(clock),
        .rst  (rst),
        .clear(tick_clear),
        .tick (tick)
    );

`ifdef UART_RX_MAJORITY_EN
    logic sample_a;
    logic sample_b;

    // Capture the two early votes that precede the deciding tick.
    always_ff @(posedge clock) begin
        if (rst) begin
            sample_a <= 1'b1;
            sample_b <= 1'b1;
        end else if (tick && tick_idx == TW'(MID - 1)) begin
            sample_a <= rx_sync;
        end else if (tick && tick_idx == TW'(MID)) begin
            sample_b <= rx_sync;
        end
    end

    assign bit_val = (sample_a & sample_b) | (sample_a & rx_sync) | (sample_b & rx_sync);
`else
    assign bit_val = rx_sync;
`endif

    assign decide     = tick && (tick_idx == DECIDE_IDX);
    assign par_expect = (PAR == PAR_ODD) ? ~(^shift_reg) : (^shift_reg);
    assign busy       = (state != IDLE);

    // Frame FSM plus output word register and handshake.
    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= IDLE;
            tick_idx   <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shift_reg  <= '0;
            parity_bad <= 1'b0;
            frame_bad  <= 1'b0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            // NOTE: the last non-blocking assignment in the block wins, so a
            // word load in STOP below overrides this handshake clear.
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (state != IDLE && tick) begin
                tick_idx <= (tick_idx == TICK_LAST) ? '0 : tick_idx + TW'(1);
            end

            case (state)
                IDLE: begin
                    tick_idx <= '0;
                    if (!rx_sync) begin
                        state <= START;
                    end
                end
                START: begin
                    if (decide) begin
                        if (bit_val) begin
                            state <= IDLE;
                        end else begin
                            state      <= DATA;
                            bit_cnt    <= '0;
                            stop_cnt   <= 1'b0;
                            parity_bad <= 1'b0;
                            frame_bad  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + BW'(1);
                        if (bit_cnt == LAST_DATA) begin
                            state <= (PAR == PAR_NONE) ? STOP : PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (decide) begin
                        parity_bad <= (bit_val != par_expect);
                        state      <= STOP;
                    end
                end
                STOP: begin
                    if (decide) begin
                        if (!bit_val) begin
                            frame_bad <= 1'b1;
                        end
                        stop_cnt <= stop_cnt + 1'b1;
                        if (stop_cnt == LAST_STOP) begin
                            // Leave at mid-bit so a back-to-back start edge is seen.
                            state <= IDLE;
                            if (!m_valid || m_ready) begin
                                m_data     <= shift_reg;
                                parity_err <= parity_bad;
                                frame_err  <= frame_bad | !bit_val;
                                m_valid    <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receiver: next-generation serial input stage for the communication subsystem. Synchronises the asynchronous line, oversamples each bit, supports configurable data width, parity mode and stop-bit count, and delivers received words over a valid/ready handshake. Parity, framing and overrun errors are flagged per word.

## Interface
Parameters:
- CLK_RATE, 100000000, system clock frequency in Hz
- BAUD_RATE, 115200, line rate in bit/s
- OVERSAMPLE, 16, ticks per bit; even, ≥4
- DATA_BITS, 8, data bits per frame, 5..9
- PARITY_MODE, 0, 0 none / 1 even / 2 odd
- STOP_BITS, 1, 1 or 2

Ports:
- Reset rst, synchronous, active-high; clock clock.
- clock  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_i  in  1  asynchronous serial line, idle high
- m_data  out  DATA_BITS  received word, LSB first on line
- m_valid  out  1  m_data and error flags valid
- m_ready  in  1  consumer accepts word
- parity_err  out  1  parity mismatch for the held word; valid with m_valid
- frame_err  out  1  stop bit sampled low for the held word; valid with m_valid
- overrun  out  1  one-cycle pulse: a word was dropped
- busy  out  1  high in every state except IDLE

## Operation
- rx_i passes a 2-FF synchroniser, reset value 1; all logic uses the synchronised signal.
- CLKS_PER_TICK = CLK_RATE / (BAUD_RATE*OVERSAMPLE), truncated; elaboration error if < 1, or if any parameter is out of range.
- Tick generator: counter 0..CLKS_PER_TICK-1; tick is a one-cycle pulse at the terminal count. Cleared on IDLE->START so the phase aligns to the falling edge.
- Per-bit tick index 0..OVERSAMPLE-1; the sample point is index OVERSAMPLE/2-1 (mid-bit).
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on synchronised low.
  - START at mid-sample: high -> IDLE (false start, no output); low -> DATA.
  - DATA: one sample per OVERSAMPLE ticks, shifted in LSB first. After DATA_BITS samples -> PARITY if PARITY_MODE≠0, else STOP.
  - PARITY: sample compared with XOR of data (even) or its inverse (odd).
  - STOP: STOP_BITS samples. Any low sample sets frame_err. After the last stop sample -> IDLE immediately (at mid-bit) to allow back-to-back frames.
- Word completion: if m_valid=0 or m_ready=1 in that cycle, load m_data, parity_err and frame_err, and set m_valid. Otherwise keep the held word, discard the new one, and pulse overrun.
- Handshake: m_valid clears on m_valid&&m_ready unless a new word loads in the same cycle; load wins.
- m_data, parity_err and frame_err remain stable while m_valid=1.
- Reset mid-frame: all state returns to IDLE, the shift register is cleared, and any partial frame is discarded.

## Timing
- Reset values: m_data=0, m_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
- Synchroniser adds 2 cycles before IDLE sees the start edge.
- m_valid asserts the cycle after the clock edge where the final stop sample is taken.
- Frame period = (1+DATA_BITS+parity+STOP_BITS) * OVERSAMPLE * CLKS_PER_TICK cycles, minus half a bit from the early return to IDLE.
- overrun is high for exactly one cycle per dropped word.

## Configuration
- UART_RX_MAJORITY_EN defined: each bit decision is a 2-of-3 majority of samples at tick indices mid-1, mid and mid+1. The decision and any resulting transition occur at tick mid+1. START false-start detection also uses the majority.
- Not defined: single sample at tick mid. Decision occurs at tick mid.

## Structure
- Package uart_pkg: rx_state_e enum, parity_mode_e (PAR_NONE, PAR_EVEN, PAR_ODD), and a function computing CLKS_PER_TICK, shared with the transmitter.
- Sub-module uart_baud_tick: tick counter with a sync clear input and a tick output, reusable by the TX side.

## Test plan
Use CLK_RATE=1600000, BAUD_RATE=100000, OVERSAMPLE=16 (1 clock per tick, 16 clocks per bit).
- 8E1, send 0xA5 with parity bit 0 -> m_data=0xA5, m_valid=1, parity_err=0, frame_err=0.
- 8O1, send 0xA5 with parity bit 0 -> m_data=0xA5, parity_err=1.
- 8N1, send 0x3C with stop bit low -> m_data=0x3C, frame_err=1; next frame 0x01 received cleanly.
- Low glitch of 4 clocks on idle line -> busy pulses, then returns to 0; no m_valid.
- m_ready=0, send 0x11 then 0x22 -> m_data holds 0x11, overrun pulses once; after m_ready=1, m_valid drops.
- rst asserted during the 3rd data bit -> outputs at reset values next cycle; subsequent 0xF0 frame received correctly. With UART_RX_MAJORITY_EN, a 1-clock high glitch at mid of a low data bit does not change that bit.
